// File: rtl/aes_pkg.sv
// Shared AES datapath types and widths.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W     = 128;
    localparam int unsigned AES_BYTE_W      = 8;
    localparam int unsigned AES_BLOCK_BYTES = AES_BLOCK_W / AES_BYTE_W;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

endpackage

// File: rtl/aes_out_buffer.sv
// First-word-fall-through output buffer for finished AES blocks.
// Define AES_OUTBUF_OVF_EN to add the overflow / drop_count outputs.
module aes_out_buffer
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [AES_BYTE_W-1:0]  in0,
    input  logic [AES_BYTE_W-1:0]  in1,
    input  logic [AES_BYTE_W-1:0]  in2,
    input  logic [AES_BYTE_W-1:0]  in3,
    input  logic [AES_BYTE_W-1:0]  in4,
    input  logic [AES_BYTE_W-1:0]  in5,
    input  logic [AES_BYTE_W-1:0]  in6,
    input  logic [AES_BYTE_W-1:0]  in7,
    input  logic [AES_BYTE_W-1:0]  in8,
    input  logic [AES_BYTE_W-1:0]  in9,
    input  logic [AES_BYTE_W-1:0]  inA,
    input  logic [AES_BYTE_W-1:0]  inB,
    input  logic [AES_BYTE_W-1:0]  inC,
    input  logic [AES_BYTE_W-1:0]  inD,
    input  logic [AES_BYTE_W-1:0]  inE,
    input  logic [AES_BYTE_W-1:0]  inF,
    input  logic                   empty_in,
    output aes_block_t             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
`ifdef AES_OUTBUF_OVF_EN
    ,
    output logic                   overflow,
    output logic [7:0]             drop_count
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    aes_block_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, valid_q;
    logic             armed_q;
    aes_block_t       wr_data;
    logic             wr_en, rd_en, drop;

    assign wr_data = {in0, in1, in2, in3, in4, in5, in6, in7,
                      in8, in9, inA, inB, inC, inD, inE, inF};

    assign rd_en = valid_q & out_ready;
    // armed_q stays low through the first edge after reset release so that edge never writes.
    assign wr_en = armed_q & ~empty_in & (~full_q | rd_en);
    assign drop  = armed_q & ~empty_in & full_q & ~rd_en;

    always_comb begin
        level_d = level_q;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
            full_q  <= (level_d == LVL_W'(DEPTH));
            valid_q <= (level_d != '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef AES_OUTBUF_OVF_EN
    logic       overflow_q;
    logic [7:0] drop_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 8'hff) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    // Storage is cleared on reset, so the head entry reads as zero while reset is held.
    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = valid_q;
    assign full      = full_q;
    assign level     = level_q;

endmodule
